// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and word select/merge helpers for the
// direct-mapped write-back data cache controller.
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 7;
    localparam int BLOCK_W  = 128;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS     = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } state_t;

    // Extract one 32-bit word from a line; word 0 sits in the low bits.
    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] line,
                                                   input logic [1:0]         sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

    // Return the line with one word replaced by store data.
    function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] line,
                                                    input logic [1:0]         sel,
                                                    input logic [WORD_W-1:0]  wdata);
        logic [BLOCK_W-1:0] merged;
        merged = line;
        merged[sel*WORD_W +: WORD_W] = wdata;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Tag/valid/dirty storage for the 128 cache sets. Single index shared by the
// combinational read and the clocked write, since both always address the
// set of the request currently being serviced.
module dcache_tag_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_dirty
);

    logic [TAG_W-1:0] tag_mem [SETS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;

    // Tag storage update on fill or store hit.
    // NOTE: tag entries carry no reset; a tag is only ever read qualified by its
    // valid bit, so clearing valid/dirty is enough and keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[index] <= wr_tag;
        end
    end

    // Valid/dirty flags; reset invalidates every line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= wr_dirty;
        end
    end

    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller. Line data
// lives in an external 128 x 128-bit RAM with a one-cycle registered read;
// tags and state flags live in dcache_tag_array.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    // CPU side
    input  logic               cpu_req,
    output logic               cpu_ready,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ack,
    // Data RAM side
    output logic               dram_en,
    output logic [INDEX_W-1:0] dram_addr,
    output logic [BLOCK_W-1:0] dram_din,
    input  logic [BLOCK_W-1:0] dram_dout,
    // Memory side
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready
);

    state_t state;
    state_t state_nxt;

    // Latched request; the byte offset within a word is never needed.
    logic [ADDR_W-1:2]  req_addr;
    logic               req_we;
    logic [WORD_W-1:0]  req_wdata;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic [ADDR_W-1:0]  req_line;

    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic               hit;

    logic               tag_wr_en;
    logic               tag_wr_dirty;

    logic               cpu_ack_nxt;
    logic [WORD_W-1:0]  cpu_rdata_nxt;
    logic               mem_req_nxt;
    logic               mem_we_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [BLOCK_W-1:0] mem_wdata_nxt;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_tag   = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign req_index = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign req_word  = req_addr[3:2];
    assign req_line  = {req_tag, req_index, {OFFSET_W{1'b0}}};

    assign cpu_ready = (state == IDLE);
    assign hit       = rd_valid && (rd_tag == req_tag);

    dcache_tag_array u_tags (
        .clk      (clk),
        .rst      (rst),
        .index    (req_index),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .wr_en    (tag_wr_en),
        .wr_tag   (req_tag),
        .wr_dirty (tag_wr_dirty)
    );

    // RAM read address: follow the CPU while idle so the line is ready in
    // LOOKUP, then hold the request's set so dram_dout stays stable.
    always_comb begin
        if (state == IDLE) begin
            dram_addr = rst ? '0 : cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
        end else begin
            dram_addr = req_index;
        end
    end

    // Capture the CPU request on acceptance; inputs are ignored afterwards.
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
        end else if (cpu_req && cpu_ready) begin
            req_addr  <= cpu_addr[ADDR_W-1:2];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, RAM/tag write strobes and next values of registered outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a branch that
        // forgot one would otherwise infer a latch.
        state_nxt     = state;
        cpu_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        dram_en       = 1'b0;
        dram_din      = '0;
        tag_wr_en     = 1'b0;
        tag_wr_dirty  = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt = LOOKUP;
                end
            end

            LOOKUP: begin
                if (hit) begin
                    cpu_ack_nxt = 1'b1;
                    state_nxt   = IDLE;
                    if (req_we) begin
                        // Write lands at the end of LOOKUP, before any
                        // back-to-back request can read the set again.
                        dram_en      = 1'b1;
                        dram_din     = put_word(dram_dout, req_word, req_wdata);
                        tag_wr_en    = 1'b1;
                        tag_wr_dirty = 1'b1;
                    end else begin
                        cpu_rdata_nxt = get_word(dram_dout, req_word);
                    end
                end else if (rd_valid && rd_dirty) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = {rd_tag, req_index, {OFFSET_W{1'b0}}};
                    mem_wdata_nxt = dram_dout;
                    state_nxt     = WRITEBACK;
                end else begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = req_line;
                    state_nxt    = REFILL;
                end
            end

            WRITEBACK: begin
                // mem_req stays high; the refill read follows immediately.
                if (mem_ready) begin
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = req_line;
                    state_nxt    = REFILL;
                end
            end

            REFILL: begin
                if (mem_ready) begin
                    mem_req_nxt  = 1'b0;
                    dram_en      = 1'b1;
                    dram_din     = req_we ? put_word(mem_rdata, req_word, req_wdata)
                                          : mem_rdata;
                    tag_wr_en    = 1'b1;
                    tag_wr_dirty = req_we;
                    cpu_ack_nxt  = 1'b1;
                    if (!req_we) begin
                        cpu_rdata_nxt = get_word(mem_rdata, req_word);
                    end
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered CPU and memory outputs; reset drops any memory transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ack   <= cpu_ack_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

endmodule
